// File: rtl/avalon_s_pipeline_bridge.sv
// Registered one-deep Avalon bridge between the arbiter device port and a
// downstream device. It breaks the grant->command and readdata/waitrequest->host
// combinational paths, and aborts a device that stalls for too long.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   host_avn_*                 arbiter-facing slave (read/write/address/byte_enable/
//                              writedata in; readdata/waitrequest out)
//   device_avn_*               device-facing master (registered command out;
//                              readdata/waitrequest in)
//   timeout_err                one-cycle pulse when a stalled device is aborted
module avalon_s_pipeline_bridge #(
  parameter int unsigned    DW       = 32,
  parameter int unsigned    AW       = 32,
  parameter int unsigned    TO_CYC   = 256,
  parameter logic [DW-1:0]  ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_avn_read,
  input  logic              host_avn_write,
  input  logic [AW-1:0]     host_avn_address,
  input  logic [DW/8-1:0]   host_avn_byte_enable,
  input  logic [DW-1:0]     host_avn_writedata,
  output logic [DW-1:0]     host_avn_readdata,
  output logic              host_avn_waitrequest,
  output logic              device_avn_read,
  output logic              device_avn_write,
  output logic [AW-1:0]     device_avn_address,
  output logic [DW/8-1:0]   device_avn_byte_enable,
  output logic [DW-1:0]     device_avn_writedata,
  input  logic [DW-1:0]     device_avn_readdata,
  input  logic              device_avn_waitrequest,
  output logic              timeout_err
);

  localparam int unsigned BEW     = DW / 8;
  localparam int unsigned CW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned TO_LAST = (TO_CYC == 0) ? 0 : TO_CYC - 1;
  localparam bit          TO_EN   = (TO_CYC != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rd_d, wr_d;
  logic [AW-1:0]    addr_d;
  logic [BEW-1:0]   be_d;
  logic [DW-1:0]    wdata_d;
  logic [DW-1:0]    rdata_d;
  logic             terr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Host only sees completion in DONE; decoded from state so no device path leaks through.
  assign host_avn_waitrequest = (host_avn_read | host_avn_write) & (state_q != DONE);

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    rd_d    = device_avn_read;
    wr_d    = device_avn_write;
    addr_d  = device_avn_address;
    be_d    = device_avn_byte_enable;
    wdata_d = device_avn_writedata;
    rdata_d = host_avn_readdata;
    terr_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (host_avn_read | host_avn_write) begin
          // Read wins when both are asserted; the write is dropped.
          rd_d    = host_avn_read;
          wr_d    = host_avn_write & ~host_avn_read;
          addr_d  = host_avn_address;
          be_d    = host_avn_byte_enable;
          wdata_d = host_avn_writedata;
          cnt_d   = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (!device_avn_waitrequest) begin
          if (device_avn_read) rdata_d = device_avn_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
        end else if (TO_EN && (cnt_q == CW'(TO_LAST))) begin
          if (device_avn_read) rdata_d = ERR_DATA;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Wraps harmlessly when the timeout is disabled.
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                <= IDLE;
      device_avn_read        <= 1'b0;
      device_avn_write       <= 1'b0;
      device_avn_address     <= '0;
      device_avn_byte_enable <= '0;
      device_avn_writedata   <= '0;
      host_avn_readdata      <= '0;
      timeout_err            <= 1'b0;
      cnt_q                  <= '0;
    end else begin
      state_q                <= state_d;
      device_avn_read        <= rd_d;
      device_avn_write       <= wr_d;
      device_avn_address     <= addr_d;
      device_avn_byte_enable <= be_d;
      device_avn_writedata   <= wdata_d;
      host_avn_readdata      <= rdata_d;
      timeout_err            <= terr_d;
      cnt_q                  <= cnt_d;
    end
  end

endmodule
